// File: rtl/mac_slave_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mac_slave_ctl
// Purpose  : Memory-mapped register slave for Catapult-generated accelerator
//            cores. It provides NUM_IN writable operand registers, NUM_OUT
//            read-only result shadows, a start/done launch FSM, sticky W1C
//            status and a level interrupt.
// Ports    : clk, arst_n         - clock, asynchronous active-low reset
//            in_dat / out_dat    - packed operand outputs / live results in
//            go / done           - launch pulse out / completion pulse in
//            irq                 - registered level interrupt
//            addr, ren, rdata    - read port (1-cycle registered rdata)
//            wen, wdata          - write port (shares addr with read)
//            waddr_error         - one-cycle write error pulse
//            raddr_error         - one-cycle read error pulse
// Options  : `define MAC_SLAVE_TIMEOUT_EN adds a RUN watchdog of
//            TIMEOUT_CYCLES cycles and STATUS bit3 TIMEOUT.
// Map      : 0x00 CTRL {IRQ_EN,START}, 0x04 STATUS {TIMEOUT,ERR,DONE,BUSY},
//            0x08 reserved, 0x10+4*i operand i, 0x10+4*(NUM_IN+j) result j
// Revision : 1.0 - initial release
// ============================================================================
module mac_slave_ctl #(
  parameter int ADDR_BITS      = 12,
  parameter int DATA_BITS      = 32,
  parameter int NUM_IN         = 3,
  parameter int NUM_OUT        = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DEBUG          = 0
) (
  input  logic                          clk,
  input  logic                          arst_n,
  output logic [NUM_IN*DATA_BITS-1:0]   in_dat,
  input  logic [NUM_OUT*DATA_BITS-1:0]  out_dat,
  output logic                          go,
  input  logic                          done,
  output logic                          irq,
  input  logic [ADDR_BITS-1:0]          addr,
  input  logic                          ren,
  output logic [DATA_BITS-1:0]          rdata,
  input  logic                          wen,
  input  logic [DATA_BITS-1:0]          wdata,
  output logic                          waddr_error,
  output logic                          raddr_error
);

  localparam int WA = ADDR_BITS - 2;   // word-index width

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Catch unusable configurations at elaboration.
  if (NUM_IN < 1 || NUM_IN > 64 || NUM_OUT < 1 || NUM_OUT > 64 ||
      DATA_BITS < 4 || TIMEOUT_CYCLES < 1 || DEBUG < 0 || DEBUG > 2 ||
      (4 + NUM_IN + NUM_OUT) > (1 << WA)) begin : g_param_err
    $error("mac_slave_ctl: parameter out of range");
  end

  logic [0:0]           r_state;
  logic                 r_irq_en, r_done_st, r_err_st;
  logic                 r_go, r_irq, r_werr, r_rerr;
  logic [DATA_BITS-1:0] r_rdata;
  logic [DATA_BITS-1:0] r_opnd   [NUM_IN];
  logic [DATA_BITS-1:0] r_shadow [NUM_OUT];

  // ---------------------------------------------------------------- decode
  logic [WA-1:0]        w_widx;
  logic                 w_aligned, w_is_ctrl, w_is_stat, w_is_rsvd;
  logic [NUM_IN-1:0]    w_opnd_sel;
  logic [NUM_OUT-1:0]   w_res_sel;

  assign w_widx    = addr[ADDR_BITS-1:2];
  assign w_aligned = (addr[1:0] == 2'b00);

  always_comb begin
    w_is_ctrl  = w_aligned && (w_widx == WA'(0));
    w_is_stat  = w_aligned && (w_widx == WA'(1));
    w_is_rsvd  = w_aligned && (w_widx == WA'(2));
    w_opnd_sel = '0;
    w_res_sel  = '0;
    for (int i = 0; i < NUM_IN; i++)
      w_opnd_sel[i] = w_aligned && (w_widx == WA'(4 + i));
    for (int j = 0; j < NUM_OUT; j++)
      w_res_sel[j] = w_aligned && (w_widx == WA'(4 + NUM_IN + j));
  end

  // ---------------------------------------------------------- write control
  logic w_busy, w_start, w_launch, w_start_rej, w_opnd_rej, w_wr_bad;
  logic w_wr_stat, w_done_set, w_spurious, w_timeout, w_tmo_st;

  assign w_busy      = (r_state == S_RUN);
  assign w_start     = wen && w_is_ctrl && wdata[0];
  assign w_launch    = w_start && !w_busy;
  // In RUN a START is rejected even when done arrives on the same edge.
  assign w_start_rej = w_start && w_busy;
  assign w_opnd_rej  = wen && (|w_opnd_sel) && w_busy;
  // Anything not CTRL/STATUS/operand is an error, including RO results.
  assign w_wr_bad    = wen && !(w_is_ctrl || w_is_stat || (|w_opnd_sel));
  assign w_wr_stat   = wen && w_is_stat;
  assign w_done_set  = w_busy && done;
  assign w_spurious  = !w_busy && done;

`ifdef MAC_SLAVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;
  logic          r_tmo_st;

  // Fires on the edge that completes the TIMEOUT_CYCLES-th RUN cycle.
  assign w_timeout = w_busy && !done && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_st  = r_tmo_st;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_st  <= 1'b0;
    end else begin
      if (w_launch)    r_tmo_cnt <= '0;
      else if (w_busy) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      r_tmo_st <= w_timeout || (r_tmo_st && !(w_wr_stat && wdata[3]));
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_tmo_st  = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_IDLE;
      r_irq_en  <= 1'b0;
      r_done_st <= 1'b0;
      r_err_st  <= 1'b0;
      r_go      <= 1'b0;
      r_irq     <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      r_go   <= w_launch;
      r_werr <= w_wr_bad || w_start_rej || w_opnd_rej;
      r_irq  <= r_irq_en && (r_done_st || r_err_st);
      if (wen && w_is_ctrl) r_irq_en <= wdata[1];
      // Hardware set takes priority over a same-cycle W1C.
      r_done_st <= w_done_set ||
                   (r_done_st && !(w_wr_stat && wdata[1]) && !w_launch);
      r_err_st  <= w_start_rej || w_opnd_rej || w_spurious || w_timeout ||
                   (r_err_st && !(w_wr_stat && wdata[2]));
      case (r_state)
        S_IDLE:  if (w_launch) r_state <= S_RUN;
        S_RUN:   if (done || w_timeout) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------- operands and shadows
  for (genvar i = 0; i < NUM_IN; i++) begin : g_opnd
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
        r_opnd[i] <= '0;
      else if (wen && w_opnd_sel[i] && !w_busy)
        r_opnd[i] <= wdata;
    end
    assign in_dat[i*DATA_BITS +: DATA_BITS] = r_opnd[i];
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_shadow
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
        r_shadow[j] <= '0;
      else if (w_done_set)
        r_shadow[j] <= out_dat[j*DATA_BITS +: DATA_BITS];
    end
  end

  // -------------------------------------------------------------- read path
  logic                 w_rd_hit;
  logic [DATA_BITS-1:0] w_rd_val;

  // The reserved word reads as zero without an error.
  assign w_rd_hit = w_is_ctrl || w_is_stat || w_is_rsvd ||
                    (|w_opnd_sel) || (|w_res_sel);

  always_comb begin
    w_rd_val = '0;
    if (w_is_ctrl) begin
      w_rd_val[1] = r_irq_en;
    end
    if (w_is_stat) begin
      w_rd_val[0] = w_busy;
      w_rd_val[1] = r_done_st;
      w_rd_val[2] = r_err_st;
      w_rd_val[3] = w_tmo_st;
    end
    for (int i = 0; i < NUM_IN; i++)
      if (w_opnd_sel[i]) w_rd_val = r_opnd[i];
    for (int j = 0; j < NUM_OUT; j++)
      if (w_res_sel[j]) w_rd_val = r_shadow[j];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      r_rerr <= ren && !w_rd_hit;
      if (ren && w_rd_hit) r_rdata <= w_rd_val;
    end
  end

  assign go          = r_go;
  assign irq         = r_irq;
  assign rdata       = r_rdata;
  assign waddr_error = r_werr;
  assign raddr_error = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_mac_slave_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_slave_ctl
// Purpose  : Directed self-checking bench for mac_slave_ctl (3 operands,
//            1 result). Inputs change on the falling edge; outputs are
//            sampled on the falling edge after the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_slave_ctl;

  logic        clk    = 1'b0;
  logic        arst_n = 1'b1;
  logic [95:0] in_dat;
  logic [31:0] out_dat = '0;
  logic        go;
  logic        done = 1'b0;
  logic        irq;
  logic [11:0] addr = '0;
  logic        ren  = 1'b0;
  logic [31:0] rdata;
  logic        wen  = 1'b0;
  logic [31:0] wdata = '0;
  logic        waddr_error, raddr_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        re;

  always #5 clk = ~clk;

  mac_slave_ctl #(
    .ADDR_BITS(12), .DATA_BITS(32), .NUM_IN(3), .NUM_OUT(1),
    .TIMEOUT_CYCLES(16), .DEBUG(0)
  ) dut (
    .clk(clk), .arst_n(arst_n), .in_dat(in_dat), .out_dat(out_dat),
    .go(go), .done(done), .irq(irq), .addr(addr), .ren(ren),
    .rdata(rdata), .wen(wen), .wdata(wdata),
    .waddr_error(waddr_error), .raddr_error(raddr_error)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d,
                          output logic e);
    @(negedge clk);
    addr = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    d = rdata;
    e = raddr_error;
  endtask

  task automatic pulse_done(input logic [31:0] res);
    @(negedge clk);
    done = 1'b1; out_dat = res;
    @(negedge clk);
    done = 1'b0; out_dat = 32'hdead_beef;
  endtask

  initial begin
    #1 arst_n = 1'b0;
    #11;
    check("rst_go", go, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_in_dat", in_dat, 96'h0);
    check("rst_werr", waddr_error, 1'b0);
    @(negedge clk) arst_n = 1'b1;

    bus_read(12'h000, rd, re); check("rd_ctrl", rd, 32'h0); check("rd_ctrl_err", re, 1'b0);
    bus_read(12'h004, rd, re); check("rd_status", rd, 32'h0);
    bus_read(12'h010, rd, re); check("rd_op0", rd, 32'h0);

    // Operand writes and readback
    bus_write(12'h010, 32'd5); check("wr_op0_err", waddr_error, 1'b0);
    bus_write(12'h014, 32'd7);
    bus_write(12'h018, 32'd3);
    bus_read(12'h010, rd, re); check("rb_op0", rd, 32'd5);
    bus_read(12'h014, rd, re); check("rb_op1", rd, 32'd7);
    bus_read(12'h018, rd, re); check("rb_op2", rd, 32'd3);
    check("in_dat", in_dat, {32'd3, 32'd7, 32'd5});

    // Launch with IRQ_EN, complete, clear DONE
    bus_write(12'h000, 32'h3);
    check("go_pulse", go, 1'b1);
    check("go_werr", waddr_error, 1'b0);
    @(negedge clk); check("go_one_cycle", go, 1'b0);
    bus_read(12'h004, rd, re); check("st_busy", rd, 32'h1);
    pulse_done(32'h26);
    bus_read(12'h004, rd, re); check("st_done", rd, 32'h2);
    bus_read(12'h01C, rd, re); check("shadow0", rd, 32'h26);
    check("irq_set", irq, 1'b1);
    bus_write(12'h004, 32'h2);
    check("irq_hold", irq, 1'b1);
    @(negedge clk); check("irq_clr", irq, 1'b0);

    // Writes during RUN
    bus_write(12'h000, 32'h1); check("go2", go, 1'b1);
    bus_write(12'h010, 32'd9); check("run_op_werr", waddr_error, 1'b1);
    bus_write(12'h000, 32'h1); check("run_start_werr", waddr_error, 1'b1);
    check("no_second_go", go, 1'b0);
    bus_read(12'h010, rd, re); check("op0_kept", rd, 32'd5);
    bus_read(12'h004, rd, re); check("st_busy_err", rd, 32'h5);
    pulse_done(32'h1234);
    bus_read(12'h004, rd, re); check("st_done_err", rd, 32'h6);
    bus_read(12'h01C, rd, re); check("shadow1", rd, 32'h1234);

    // Address errors
    bus_read(12'h040, rd, re); check("rd_unmap_err", re, 1'b1);
    check("rd_unmap_hold", rd, 32'h1234);
    bus_write(12'h01C, 32'hff); check("wr_ro_err", waddr_error, 1'b1);
    bus_write(12'h011, 32'hff); check("wr_misal_err", waddr_error, 1'b1);
    bus_read(12'h01C, rd, re); check("ro_unchanged", rd, 32'h1234);
    check("rd_ok_noerr", re, 1'b0);
    check("in_dat_unchanged", in_dat, {32'd3, 32'd7, 32'd5});

    // Spurious done in IDLE
    bus_write(12'h004, 32'h6);
    bus_read(12'h004, rd, re); check("st_w1c", rd, 32'h0);
    pulse_done(32'h55);
    bus_read(12'h004, rd, re); check("st_spurious", rd, 32'h4);
    bus_read(12'h01C, rd, re); check("no_capture", rd, 32'h1234);

    // Same-cycle read and write return the pre-write value
    @(negedge clk);
    addr = 12'h014; wdata = 32'h55; ren = 1'b1; wen = 1'b1;
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    check("rw_prewrite", rdata, 32'd7);
    bus_read(12'h014, rd, re); check("rw_postwrite", rd, 32'h55);

    // DONE set and W1C on the same edge: set wins
    bus_write(12'h004, 32'h4);
    bus_write(12'h000, 32'h1);
    @(negedge clk);
    done = 1'b1; out_dat = 32'h77; addr = 12'h004; wdata = 32'h2; wen = 1'b1;
    @(negedge clk);
    done = 1'b0; wen = 1'b0;
    bus_read(12'h004, rd, re); check("set_wins", rd, 32'h2);
    bus_read(12'h01C, rd, re); check("shadow2", rd, 32'h77);

    // done and START on the same edge: completion, START rejected
    bus_write(12'h000, 32'h1);
    @(negedge clk);
    done = 1'b1; out_dat = 32'h88; addr = 12'h000; wdata = 32'h1; wen = 1'b1;
    @(negedge clk);
    done = 1'b0; wen = 1'b0;
    check("done_start_werr", waddr_error, 1'b1);
    check("done_start_nogo", go, 1'b0);
    bus_read(12'h004, rd, re); check("done_start_st", rd, 32'h6);

    // Reset in RUN, later done is spurious
    bus_write(12'h000, 32'h1);
    @(negedge clk) arst_n = 1'b0;
    #1 check("midrun_rst_in", in_dat, 96'h0);
    @(negedge clk) arst_n = 1'b1;
    pulse_done(32'h99);
    bus_read(12'h004, rd, re); check("midrun_spurious", rd, 32'h4);
    bus_read(12'h01C, rd, re); check("midrun_shadow", rd, 32'h0);

`ifdef MAC_SLAVE_TIMEOUT_EN
    bus_write(12'h004, 32'hF);
    bus_write(12'h000, 32'h1);
    repeat (16) @(negedge clk);
    bus_read(12'h004, rd, re); check("timeout_st", rd, 32'hC);
    bus_read(12'h01C, rd, re); check("timeout_shadow", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
